// File: rtl/frame_update_scheduler.sv
// Per-frame sprite update sequencer: detects vblank start, divides the frame
// rate and strobes each object once, in order, while the beam is off-screen.
module frame_update_scheduler #(
  parameter int V_ACTIVE  = 480,
  parameter int NUM_OBJ   = 3,
  parameter int IDX_W     = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [10:0]        yPixel,
  input  logic               enable,
  input  logic [3:0]         wasd,
  input  logic [3:0]         arrows,
  output logic [NUM_OBJ-1:0] upd_strobe,
  output logic [IDX_W-1:0]   upd_idx,
  output logic [3:0]         upd_dir,
  output logic               seq_busy,
  output logic               frame_tick,
  output logic [15:0]        frame_count,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, LATCH, STEP, DONE} state_t;

  localparam logic [3:0]       DIV_LAST  = 4'(FRAME_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OBJ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [NUM_OBJ-1:0] STROBE0 = NUM_OBJ'(1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       divCnt;
  logic [3:0]       wasdLatch;
  logic [3:0]       arrowsLatch;
  logic             prevVb;
  logic             vb;
  logic             vblankStart;
  logic             seqStart;

  assign vb          = (yPixel >= 11'(V_ACTIVE));
  assign vblankStart = vb & ~prevVb;
  assign seqStart    = vblankStart && (divCnt == DIV_LAST) && enable && (state == IDLE);

  // Pressing both opposite directions cancels that axis entirely.
  function automatic logic [3:0] cancelOpposite(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (d[0] && d[2]) begin
      r[0] = 1'b0;
      r[2] = 1'b0;
    end
    if (d[1] && d[3]) begin
      r[1] = 1'b0;
      r[3] = 1'b0;
    end
    return r;
  endfunction

  // Object 1 is player-one (wasd), object 2 player-two (arrows), rest autonomous.
  function automatic logic [3:0] dirFor(input logic [IDX_W-1:0] i,
                                        input logic [3:0] w,
                                        input logic [3:0] a);
    logic [3:0] r;
    r = 4'b0000;
    if (32'(i) == 32'd1) r = w;
    else if (32'(i) == 32'd2) r = a;
    return r;
  endfunction

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      idx         <= '0;
      divCnt      <= 4'd0;
      wasdLatch   <= 4'd0;
      arrowsLatch <= 4'd0;
      prevVb      <= 1'b1;
      upd_strobe  <= '0;
      upd_idx     <= '0;
      upd_dir     <= 4'd0;
      seq_busy    <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= 16'd0;
      overrun     <= 1'b0;
    end else begin
      prevVb     <= vb;
      frame_tick <= vblankStart;

      // Frame accounting keeps running even if a glitch lands mid-sequence.
      if (vblankStart) begin
        frame_count <= frame_count + 16'd1;
        if (divCnt == DIV_LAST) divCnt <= 4'd0;
        else                    divCnt <= divCnt + 4'd1;
      end

      case (state)
        IDLE: begin
          if (seqStart) begin
            state    <= LATCH;
            seq_busy <= 1'b1;
          end
        end
        LATCH: begin
          wasdLatch   <= cancelOpposite(wasd);
          arrowsLatch <= cancelOpposite(arrows);
          idx         <= '0;
          state       <= STEP;
          upd_strobe  <= STROBE0;
          upd_idx     <= '0;
          upd_dir     <= dirFor('0, cancelOpposite(wasd), cancelOpposite(arrows));
        end
        STEP: begin
          if (!vb) begin
            // Beam is back on-screen: drop the rest rather than tear.
            overrun    <= 1'b1;
            state      <= IDLE;
            idx        <= '0;
            upd_strobe <= '0;
            upd_idx    <= '0;
            upd_dir    <= 4'd0;
            seq_busy   <= 1'b0;
          end else if (idx == IDX_LAST) begin
            state      <= DONE;
            idx        <= '0;
            upd_strobe <= '0;
            upd_idx    <= '0;
            upd_dir    <= 4'd0;
          end else begin
            idx        <= idx + IDX_ONE;
            upd_strobe <= upd_strobe << 1;
            upd_idx    <= idx + IDX_ONE;
            upd_dir    <= dirFor(idx + IDX_ONE, wasdLatch, arrowsLatch);
          end
        end
        DONE: begin
          state    <= IDLE;
          seq_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          upd_strobe <= '0;
          upd_idx    <= '0;
          upd_dir    <= 4'd0;
          seq_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Scoreboard bench: two scheduler instances (divide-by-1 and divide-by-3);
// stimulus pushes expected strobes/ticks, a negedge monitor pops and compares.
module tb_frame_update_scheduler;

  logic        clk = 1'b0;
  logic        rstA, rstB;
  logic [10:0] yA, yB;
  logic        enA, enB;
  logic [3:0]  wasdA, arrowsA, wasdB, arrowsB;

  logic [2:0]  strA, strB;
  logic [1:0]  idxA, idxB;
  logic [3:0]  dirA, dirB;
  logic        busyA, busyB, tickA, tickB, ovA, ovB;
  logic [15:0] fcA, fcB;

  int nCompared = 0;
  int nMismatch = 0;
  int expFcA = 0;
  int expFcB = 0;
  int nTickB = 0;

  logic [8:0]  qA[$];
  logic [8:0]  qB[$];
  logic [15:0] tickQA[$];
  logic [15:0] tickQB[$];

  always #5 clk = ~clk;

  frame_update_scheduler #(.V_ACTIVE(480), .NUM_OBJ(3), .IDX_W(2), .FRAME_DIV(1)) dutA (
    .CLOCK(clk), .RESET(rstA), .yPixel(yA), .enable(enA), .wasd(wasdA), .arrows(arrowsA),
    .upd_strobe(strA), .upd_idx(idxA), .upd_dir(dirA), .seq_busy(busyA),
    .frame_tick(tickA), .frame_count(fcA), .overrun(ovA));

  frame_update_scheduler #(.V_ACTIVE(480), .NUM_OBJ(3), .IDX_W(2), .FRAME_DIV(3)) dutB (
    .CLOCK(clk), .RESET(rstB), .yPixel(yB), .enable(enB), .wasd(wasdB), .arrows(arrowsB),
    .upd_strobe(strB), .upd_idx(idxB), .upd_dir(dirB), .seq_busy(busyB),
    .frame_tick(tickB), .frame_count(fcB), .overrun(ovB));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: every strobe or tick the DUTs present is matched against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (strA != 3'b000) begin
        if (qA.size() == 0) check("A_unexpected_strobe", {23'd0, strA, idxA, dirA}, 32'd0);
        else begin
          logic [8:0] e;
          e = qA.pop_front();
          $display("A strobe %b idx %0d dir %b (exp %b/%0d/%b)", strA, idxA, dirA, e[8:6], e[5:4], e[3:0]);
          check("A_strobe", {23'd0, strA, idxA, dirA}, {23'd0, e});
        end
      end
      if (tickA) begin
        if (tickQA.size() == 0) check("A_unexpected_tick", {16'd0, fcA}, 32'hFFFF_FFFF);
        else begin
          logic [15:0] f;
          f = tickQA.pop_front();
          $display("A tick frame_count %0d (exp %0d)", fcA, f);
          check("A_tick_count", {16'd0, fcA}, {16'd0, f});
        end
      end
      if (strB != 3'b000) begin
        if (qB.size() == 0) check("B_unexpected_strobe", {23'd0, strB, idxB, dirB}, 32'd0);
        else begin
          logic [8:0] e;
          e = qB.pop_front();
          $display("B strobe %b idx %0d dir %b (exp %b/%0d/%b)", strB, idxB, dirB, e[8:6], e[5:4], e[3:0]);
          check("B_strobe", {23'd0, strB, idxB, dirB}, {23'd0, e});
        end
      end
      if (tickB) begin
        nTickB++;
        if (tickQB.size() == 0) check("B_unexpected_tick", {16'd0, fcB}, 32'hFFFF_FFFF);
        else begin
          logic [15:0] f;
          f = tickQB.pop_front();
          $display("B tick frame_count %0d (exp %0d)", fcB, f);
          check("B_tick_count", {16'd0, fcB}, {16'd0, f});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic setY(input bit useB, input logic [10:0] v);
    if (useB) yB = v;
    else      yA = v;
  endtask

  task automatic pushSeq(input bit useB, input logic [3:0] dw, input logic [3:0] da);
    if (useB) begin
      qB.push_back({3'b001, 2'd0, 4'b0000});
      qB.push_back({3'b010, 2'd1, dw});
      qB.push_back({3'b100, 2'd2, da});
    end else begin
      qA.push_back({3'b001, 2'd0, 4'b0000});
      qA.push_back({3'b010, 2'd1, dw});
      qA.push_back({3'b100, 2'd2, da});
    end
  endtask

  task automatic pushTick(input bit useB);
    if (useB) begin
      expFcB++;
      tickQB.push_back(16'(expFcB));
    end else begin
      expFcA++;
      tickQA.push_back(16'(expFcA));
    end
  endtask

  // One vblank start; checks seq_busy over E+1..E+7 and scrambles inputs after LATCH.
  task automatic doFrame(input bit useB, input bit seq, input logic [3:0] dw, input logic [3:0] da);
    pushTick(useB);
    if (seq) pushSeq(useB, dw, da);
    @(posedge clk); #1 setY(useB, 11'd479);
    @(posedge clk); #1 setY(useB, 11'd480);
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 2) begin
        wasdA = ~wasdA; arrowsA = ~arrowsA;
        wasdB = ~wasdB; arrowsB = ~arrowsB;
      end
      check(useB ? "B_seq_busy" : "A_seq_busy", {31'd0, useB ? busyB : busyA}, {31'd0, seq && (k <= 5)});
    end
  endtask

  initial begin
    rstA = 1'b1; rstB = 1'b1;
    yA = 11'd500; yB = 11'd500;
    enA = 1'b1; enB = 1'b1;
    wasdA = 4'b0000; arrowsA = 4'b0000;
    wasdB = 4'b0001; arrowsB = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobe", {29'd0, strA}, 32'd0);
    check("rst_idx_dir", {26'd0, idxA, dirA}, 32'd0);
    check("rst_flags", {28'd0, busyA, tickA, ovA, 1'b0}, 32'd0);
    check("rst_count", {16'd0, fcA}, 32'd0);

    // Release inside vblank: no spurious tick.
    rstA = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("rel_vb_count", {16'd0, fcA}, 32'd0);

    enA = 1'b0;
    doFrame(1'b0, 1'b0, 4'd0, 4'd0);
    check("first_frame_count", {16'd0, fcA}, 32'd1);

    enA = 1'b1;
    wasdA = 4'b0001; arrowsA = 4'b1000;
    doFrame(1'b0, 1'b1, 4'b0001, 4'b1000);
    wasdA = 4'b0101; arrowsA = 4'b1010;
    doFrame(1'b0, 1'b1, 4'b0000, 4'b0000);
    wasdA = 4'b0011; arrowsA = 4'b1100;
    doFrame(1'b0, 1'b1, 4'b0011, 4'b1100);
    check("no_overrun_yet", {31'd0, ovA}, 32'd0);

    enA = 1'b0;
    doFrame(1'b0, 1'b0, 4'd0, 4'd0);
    doFrame(1'b0, 1'b0, 4'd0, 4'd0);
    check("en_low_count", {16'd0, fcA}, 32'd6);
    enA = 1'b1;
    wasdA = 4'b0100; arrowsA = 4'b0010;
    doFrame(1'b0, 1'b1, 4'b0100, 4'b0010);

    // Abort: beam leaves vblank while object 0 is being strobed.
    wasdA = 4'b0001; arrowsA = 4'b1000;
    pushTick(1'b0);
    qA.push_back({3'b001, 2'd0, 4'b0000});
    @(posedge clk); #1 yA = 11'd479;
    @(posedge clk); #1 yA = 11'd480;
    @(posedge clk);
    @(posedge clk); #1 yA = 11'd0;
    @(posedge clk);
    @(negedge clk);
    check("abort_overrun", {31'd0, ovA}, 32'd1);
    check("abort_busy", {31'd0, busyA}, 32'd0);
    repeat (4) @(posedge clk);

    wasdA = 4'b1000; arrowsA = 4'b0001;
    doFrame(1'b0, 1'b1, 4'b1000, 4'b0001);
    check("overrun_sticky", {31'd0, ovA}, 32'd1);

    // Asynchronous reset in the middle of STEP.
    wasdA = 4'b0001; arrowsA = 4'b1000;
    pushTick(1'b0);
    qA.push_back({3'b001, 2'd0, 4'b0000});
    @(posedge clk); #1 yA = 11'd479;
    @(posedge clk); #1 yA = 11'd480;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rstA = 1'b1;
    #1;
    check("async_rst_strobe", {29'd0, strA}, 32'd0);
    check("async_rst_flags", {29'd0, busyA, ovA, tickA}, 32'd0);
    check("async_rst_count", {16'd0, fcA}, 32'd0);
    expFcA = 0;
    repeat (2) @(posedge clk);
    #1 rstA = 1'b0;
    repeat (3) @(posedge clk);
    wasdA = 4'b0010; arrowsA = 4'b0100;
    doFrame(1'b0, 1'b1, 4'b0010, 4'b0100);
    check("post_rst_count", {16'd0, fcA}, 32'd1);

    // Divide-by-3 instance: seven frames, sequences on frames 3 and 6.
    rstB = 1'b0;
    repeat (4) @(posedge clk);
    for (int f = 1; f <= 7; f++) begin
      wasdB = 4'b0001; arrowsB = 4'b1000;
      doFrame(1'b1, (f % 3) == 0, 4'b0001, 4'b1000);
    end
    check("B_frame_count", {16'd0, fcB}, 32'd7);
    check("B_tick_total", nTickB, 32'd7);

    // Reset mid-divide: divider restarts, so only the third new frame sequences.
    @(posedge clk); #1 rstB = 1'b1;
    @(posedge clk); #1 rstB = 1'b0;
    expFcB = 0;
    for (int f = 1; f <= 3; f++) begin
      wasdB = 4'b0001; arrowsB = 4'b1000;
      doFrame(1'b1, f == 3, 4'b0001, 4'b1000);
    end
    check("B_post_rst_count", {16'd0, fcB}, 32'd3);

    repeat (3) @(posedge clk);
    #1;
    check("A_queue_drained", qA.size() + tickQA.size(), 32'd0);
    check("B_queue_drained", qB.size() + tickQB.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
